fpu_result_stage: RTL and testbench

FPU_RESULT_STAGE -- requirements
Module: fpu_result_stage

---
 rtl/fpu_result_stage.sv | 99 +++++++++
 tb/tb_fpu_result_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_stage.sv
// fpu_result_stage: registered result FIFO behind the FP subtractor; each word is classified on entry.
// Optional sticky exception flags (flag_clr / sticky_flags) are compiled in when FPU_STICKY_FLAGS_EN is defined.
module fpu_result_stage #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic [3:0]             out_flags,
`ifdef FPU_STICKY_FLAGS_EN
  input  logic                   flag_clr,
  output logic [3:0]             sticky_flags,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef struct packed {
    logic [3:0]  flags;
    logic [31:0] result;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [3:0]       in_flags;
  entry_t           head;

  // Flag order is {nan, inf, denorm, zero}; the sign bit never affects the class.
  function automatic logic [3:0] classify(input logic [31:0] word);
    logic exp_zero;
    logic exp_ones;
    logic man_zero;
    exp_zero = (word[30:23] == 8'h00);
    exp_ones = (word[30:23] == 8'hFF);
    man_zero = (word[22:0] == 23'h0);
    classify = {exp_ones & ~man_zero, exp_ones & man_zero,
                exp_zero & ~man_zero, exp_zero & man_zero};
  endfunction

  assign in_ready   = (count < FULL_COUNT);
  assign out_valid  = (count != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign in_flags   = classify(in_result);
  assign head       = mem[rd_ptr];
  assign out_result = out_valid ? head.result : 32'h0;
  assign out_flags  = out_valid ? head.flags : 4'h0;

  // Storage is not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{flags: in_flags, result: in_result};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FPU_STICKY_FLAGS_EN
  // A clear wins over history but not over the word accepted on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= 4'h0;
    end else if (flag_clr) begin
      sticky_flags <= push ? in_flags : 4'h0;
    end else if (push) begin
      sticky_flags <= sticky_flags | in_flags;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_result_stage.sv
// tb_fpu_result_stage: randomized plus directed stimulus, queue scoreboard checked by a monitor process.
// Define FPU_STICKY_FLAGS_EN for both files to exercise the sticky flag option.
module tb_fpu_result_stage;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_result;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_result;
  logic [3:0]             out_flags;
  logic                   flag_clr;
  logic [3:0]             sticky_flags;
  logic [$clog2(DEPTH):0] count;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] sticky_m;
  int         checks;
  int         errors;

  fpu_result_stage #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
`ifdef FPU_STICKY_FLAGS_EN
    .flag_clr     (flag_clr),
    .sticky_flags (sticky_flags),
`endif
    .count        (count)
  );

`ifndef FPU_STICKY_FLAGS_EN
  assign sticky_flags = 4'h0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference classification straight from the IEEE-754 field rules.
  function automatic logic [3:0] ref_class(input logic [31:0] w);
    int e;
    int m;
    e = int'(w[30:23]);
    m = int'(w[22:0]);
    if (e == 0) return (m == 0) ? 4'b0001 : 4'b0010;
    if (e == 255) return (m == 0) ? 4'b0100 : 4'b1000;
    return 4'b0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic ordy, input logic clr);
    @(negedge clk);
    in_valid  = v;
    in_result = d;
    out_ready = ordy;
    flag_clr  = clr;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w[30:0] = 31'h0;
      1: w[30:23] = 8'h00;
      2: begin w[30:23] = 8'hFF; w[22:0] = 23'h0; end
      3: begin w[30:23] = 8'hFF; w[22:0] = 23'h0 | $urandom_range(1, 8388607); end
      default: ;
    endcase
    return w;
  endfunction

  // Monitor: compare against the model, then apply this cycle's handshakes to it.
  initial begin
    logic take;
    logic give;
    logic [3:0] fl;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        exp_q.delete();
        sticky_m = 4'h0;
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
        checkOutput("rst_count", 32'(count), 32'h0);
        checkOutput("rst_out_result", out_result, 32'h0);
        checkOutput("rst_out_flags", 32'(out_flags), 32'h0);
`ifdef FPU_STICKY_FLAGS_EN
        checkOutput("rst_sticky", 32'(sticky_flags), 32'h0);
`endif
      end else begin
        checkOutput("count", 32'(count), 32'(exp_q.size()));
        checkOutput("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
        checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          checkOutput("out_result", out_result, exp_q[0].res);
          checkOutput("out_flags", 32'(out_flags), 32'(exp_q[0].flags));
        end else begin
          checkOutput("idle_result", out_result, 32'h0);
          checkOutput("idle_flags", 32'(out_flags), 32'h0);
        end
`ifdef FPU_STICKY_FLAGS_EN
        checkOutput("sticky", 32'(sticky_flags), 32'(sticky_m));
`endif
        take = out_ready && (exp_q.size() != 0);
        give = in_valid && (exp_q.size() < DEPTH);
        fl   = ref_class(in_result);
        if (take) void'(exp_q.pop_front());
        if (give) exp_q.push_back('{res: in_result, flags: fl});
        if (flag_clr) sticky_m = give ? fl : 4'h0;
        else if (give) sticky_m = sticky_m | fl;
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_result = 32'h0;
    out_ready = 1'b0;
    flag_clr = 1'b0;
    checks = 0;
    errors = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First word lands one cycle after the accepting edge.
    applyStimulus(1'b1, 32'h40400000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    checkOutput("first_out_valid", 32'(out_valid), 32'h1);
    checkOutput("first_result", out_result, 32'h40400000);
    checkOutput("first_flags", 32'(out_flags), 32'h0);
    checkOutput("first_count", 32'(count), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // One word of each class, then drain.
    applyStimulus(1'b1, 32'h00000000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h80000001, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7F800000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7FC00000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    checkOutput("class_zero_head", 32'(out_flags), 32'h1);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Overfill: the fifth word must be refused.
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 32'h3F800000 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    checkOutput("full_count", 32'(count), 32'h4);
    checkOutput("full_in_ready", 32'(in_ready), 32'h0);
    checkOutput("full_head", out_result, 32'h3F800001);

    // Full with both sides active for 8 cycles, across pointer wrap.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h41000000 + 32'(i), 1'b1, 1'b0);
    repeat (DEPTH + 1) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 15) == 0));
    end
    repeat (DEPTH + 1) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset pulse inside a cycle with three entries held.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hC0000000 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("midrst_count", 32'(count), 32'h0);
    #1 rst = 1'b0;
    applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #2;
    checkOutput("post_rst_result", out_result, 32'h12345678);

`ifdef FPU_STICKY_FLAGS_EN
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h7F800000, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hFFC00001, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #2;
    checkOutput("sticky_inf_nan", 32'(sticky_flags), 32'hC);
    applyStimulus(1'b1, 32'h80000000, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #2;
    checkOutput("sticky_clr_zero", 32'(sticky_flags), 32'h1);
`endif

    repeat (DEPTH + 2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    #3;
    checkOutput("final_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
